// File: rtl/rx_sync.sv
// rx_sync: matched-filter FIR with per-symbol decimation and automatic energy-based phase search.
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        asynchronous active-low reset
//   enable     clock enable; low freezes all state and suppresses sym_valid
//   rx_in      signed upsampled input sample
//   auto_en    1 = use searched phase, 0 = use phase_in
//   phase_in   manual decimation phase
//   rx_out     hard decision, 1 = non-negative filter output
//   soft_out   saturated, rescaled filter output at the decision
//   sym_valid  one-cycle strobe when rx_out/soft_out update
//   phase_out  decimation phase currently in use
//   locked     at least one search window has completed since reset
module rx_sync #(
    parameter int UPSAMPLE   = 4,
    parameter int NCOEF      = 24,
    parameter int COEF_NBITS = 8,
    parameter logic [NCOEF*COEF_NBITS-1:0] COEF = '0,
    parameter int COEF_FBITS = 7,
    parameter int DATA_NBITS = 8,
    parameter int DATA_FBITS = 7,
    parameter int OUT_NBITS  = 8,
    parameter int OUT_FBITS  = 7,
    parameter int LOG_WIN    = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic signed [DATA_NBITS-1:0]   rx_in,
    input  logic                           auto_en,
    input  logic [$clog2(UPSAMPLE)-1:0]    phase_in,
    output logic                           rx_out,
    output logic signed [OUT_NBITS-1:0]    soft_out,
    output logic                           sym_valid,
    output logic [$clog2(UPSAMPLE)-1:0]    phase_out,
    output logic                           locked
);
    localparam int PW   = $clog2(UPSAMPLE);
    localparam int PN   = DATA_NBITS + COEF_NBITS;
    localparam int FULL = PN + $clog2(NCOEF);
    localparam int SH   = DATA_FBITS + COEF_FBITS - OUT_FBITS;
    localparam int AW   = FULL + LOG_WIN;

    function automatic logic signed [COEF_NBITS-1:0] tap(input int i);
        return COEF[(NCOEF-1-i)*COEF_NBITS +: COEF_NBITS];
    endfunction

    logic signed [PN-1:0]        prod_q  [NCOEF];
    logic signed [FULL-1:0]      chain_q [NCOEF];
    logic [AW-1:0]               acc_q   [UPSAMPLE];
    logic [AW-1:0]               acc_d   [UPSAMPLE];
    logic [PW-1:0]               cnt_q, phase_sel_q, phase, best_d;
    logic [LOG_WIN-1:0]          win_q;
    logic                        rx_q, valid_q, locked_q, decide, win_end, fits;
    logic signed [OUT_NBITS-1:0] soft_q, soft_d;
    logic signed [FULL-1:0]      y, sh_y;
    logic [FULL-1:0]             abs_y;
    logic [AW-1:0]               best_v;

    assign y         = chain_q[NCOEF-1];
    assign phase     = auto_en ? phase_sel_q : phase_in;
    assign decide    = cnt_q == phase;
    assign win_end   = (cnt_q == PW'(UPSAMPLE-1)) && (&win_q);
    assign phase_out = phase;
    assign rx_out    = rx_q;
    assign soft_out  = soft_q;
    assign sym_valid = valid_q;
    assign locked    = locked_q;

    // Saturation: the shifted value fits when all bits from the output sign bit upward agree.
    always_comb begin
        abs_y  = y[FULL-1] ? -y : y;
        sh_y   = y >>> SH;
        fits   = (&sh_y[FULL-1:OUT_NBITS-1]) | ~(|sh_y[FULL-1:OUT_NBITS-1]);
        soft_d = fits ? sh_y[OUT_NBITS-1:0] : {sh_y[FULL-1], {(OUT_NBITS-1){~sh_y[FULL-1]}}};
    end

    // Argmax runs over the accumulators including this cycle's |y|; strict > keeps the lowest index on ties.
    always_comb begin
        for (int i = 0; i < UPSAMPLE; i++)
            acc_d[i] = acc_q[i] + ((cnt_q == PW'(i)) ? AW'(abs_y) : '0);
        best_d = '0;
        best_v = acc_d[0];
        for (int i = 1; i < UPSAMPLE; i++)
            if (acc_d[i] > best_v) begin
                best_v = acc_d[i];
                best_d = PW'(i);
            end
    end

    // Product register followed by a transposed adder chain; chain tail is the filter output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCOEF; i++) begin
                prod_q[i]  <= '0;
                chain_q[i] <= '0;
            end
        end else if (enable) begin
            for (int i = 0; i < NCOEF; i++)
                prod_q[i] <= rx_in * tap(i);
            chain_q[0] <= FULL'(prod_q[0]);
            for (int i = 1; i < NCOEF; i++)
                chain_q[i] <= chain_q[i-1] + FULL'(prod_q[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            win_q       <= '0;
            phase_sel_q <= '0;
            rx_q        <= 1'b0;
            soft_q      <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            for (int i = 0; i < UPSAMPLE; i++)
                acc_q[i] <= '0;
        end else begin
            valid_q <= enable && decide;
            if (enable) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == PW'(UPSAMPLE-1))
                    win_q <= win_q + 1'b1;
                if (decide) begin
                    rx_q   <= ~y[FULL-1];
                    soft_q <= soft_d;
                end
                for (int i = 0; i < UPSAMPLE; i++)
                    acc_q[i] <= win_end ? '0 : acc_d[i];
                if (win_end) begin
                    phase_sel_q <= best_d;
                    locked_q    <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rx_sync.sv
// tb_rx_sync: directed and randomized checks of rx_sync against a convolution-level reference model.
module tb_rx_sync;
    localparam int U = 4, N = 4, LW = 3;

    logic              clk = 1'b0, rst = 1'b0, enable = 1'b1, auto_en = 1'b0;
    logic signed [7:0] rx_in = '0;
    logic [1:0]        phase_in = 2'd2;
    logic              rx_out, sym_valid, locked;
    logic signed [7:0] soft_out;
    logic [1:0]        phase_out;

    int n_chk = 0, n_fail = 0;
    int cf [N] = '{16, 32, 48, 64};
    int hist [$];
    int e, sel, m_soft, last_tx;
    longint acc [U];
    bit lk, m_valid, m_rx;

    always #5 clk = ~clk;

    rx_sync #(
        .UPSAMPLE(4), .NCOEF(4), .COEF_NBITS(8), .COEF(32'h10203040), .COEF_FBITS(7),
        .DATA_NBITS(8), .DATA_FBITS(7), .OUT_NBITS(8), .OUT_FBITS(7), .LOG_WIN(3)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .rx_in(rx_in), .auto_en(auto_en),
        .phase_in(phase_in), .rx_out(rx_out), .soft_out(soft_out), .sym_valid(sym_valid),
        .phase_out(phase_out), .locked(locked)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        e = 0;
        hist.delete();
        for (int i = 0; i < U; i++) acc[i] = 0;
        sel = 0; lk = 0; m_valid = 0; m_rx = 0; m_soft = 0;
    endtask

    // One enabled edge: y is the convolution of past accepted samples with the taps, delayed two edges.
    task automatic model_edge();
        longint y, q;
        int best;
        if (!enable) m_valid = 0;
        else begin
            y = 0;
            for (int j = 0; j < N; j++)
                if (e - 2 - j >= 0) y += longint'(cf[N-1-j]) * hist[e-2-j];
            m_valid = (e % U) == (auto_en ? sel : int'(phase_in));
            if (m_valid) begin
                q = y >>> 7;
                m_rx = y >= 0;
                m_soft = q > 127 ? 127 : q < -128 ? -128 : int'(q);
            end
            acc[e % U] += y < 0 ? -y : y;
            if (e % U == U - 1 && (e / U) % (1 << LW) == (1 << LW) - 1) begin
                best = 0;
                for (int i = 1; i < U; i++) if (acc[i] > acc[best]) best = i;
                sel = best;
                for (int i = 0; i < U; i++) acc[i] = 0;
                lk = 1;
            end
            hist.push_back(int'(rx_in));
            e++;
        end
    endtask

    task automatic step(input int x, input bit en);
        rx_in = 8'(x);
        enable = en;
        @(posedge clk);
        model_edge();
        #1;
        chk("sym_valid", sym_valid, m_valid);
        chk("rx_out", rx_out, m_rx);
        chk("soft_out", soft_out, m_soft);
        chk("phase_out", phase_out, auto_en ? sel : int'(phase_in));
        chk("locked", locked, lk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", sym_valid, 0);
        chk("rst_rx", rx_out, 0);
        chk("rst_soft", soft_out, 0);
        chk("rst_locked", locked, 0);
        chk("rst_phase", phase_out, auto_en ? 0 : int'(phase_in));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Symbols of +-100 placed at counter 2, zero elsewhere; optionally check decisions against them.
    task automatic burst(input int n, input bit chk_sign);
        int x;
        for (int i = 0; i < n; i++) begin
            x = (e % U == 2) ? ($urandom_range(0, 1) ? 100 : -100) : 0;
            if (e % U == 2) last_tx = x;
            step(x, 1'b1);
            if (chk_sign && m_valid) begin
                chk("sym_sign", rx_out, last_tx >= 0);
                chk("sym_soft", soft_out, last_tx >= 0 ? 50 : -50);
            end
        end
    endtask

    initial begin
        model_reset();
        last_tx = 0;
        do_reset();
        auto_en = 1'b1;
        #1 chk("rst_phase_auto", phase_out, 0);
        auto_en = 1'b0;
        phase_in = 2'd0;
        repeat (6) step(0, 1'b1);
        phase_in = 2'((e + 2) % U);
        step(64, 1'b1);
        step(0, 1'b1);
        step(0, 1'b1);
        chk("imp_valid", sym_valid, 1);
        chk("imp_soft", soft_out, 32);
        chk("imp_rx", rx_out, 1);
        repeat (10) step(127, 1'b1);
        chk("sat_hi", soft_out, 127);
        chk("sat_hi_rx", rx_out, 1);
        repeat (10) step(-128, 1'b1);
        chk("sat_lo", soft_out, -128);
        chk("sat_lo_rx", rx_out, 0);
        auto_en = 1'b1;
        for (int i = 0; i < 320; i++) begin
            if (i % 40 == 0) begin
                auto_en = $urandom_range(0, 2) != 0;
                phase_in = 2'($urandom_range(0, 3));
            end
            step(int'($urandom_range(0, 255)) - 128, $urandom_range(0, 7) != 0);
        end
        auto_en = 1'b1;
        do_reset();
        burst(31, 1'b0);
        chk("lock_early", locked, 0);
        burst(1, 1'b0);
        chk("lock_win", locked, 1);
        chk("auto_phase", phase_out, 0);
        burst(16, 1'b1);
        auto_en = 1'b0;
        phase_in = 2'd1;
        burst(16, 1'b0);
        phase_in = 2'd0;
        burst(16, 1'b1);
        auto_en = 1'b1;
        do_reset();
        repeat (10) step(int'($urandom_range(0, 255)) - 128, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(int'($urandom_range(0, 255)) - 128, 1'b0);
            chk("gate_valid", sym_valid, 0);
        end
        repeat (21) step(int'($urandom_range(0, 255)) - 128, 1'b1);
        chk("gate_lock_early", locked, 0);
        step(int'($urandom_range(0, 255)) - 128, 1'b1);
        chk("gate_lock", locked, 1);
        repeat (8) step(int'($urandom_range(0, 255)) - 128, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rx_sync.md
# rx_sync

Receive-side matched filter and symbol-timing block: the successor to the single-phase receiver in the DSP chain. It applies a parametrised FIR (matched filter) to the upsampled baseband stream and decimates to one decision per symbol. It produces both a hard bit and a saturated soft sample with a valid strobe. Decimation phase is either forced externally or selected automatically by a per-phase energy search over a programmable window; the block sits between the channel model and the BER counter.

## Interface
- UPSAMPLE, 4, samples per symbol; power of two, ≥2
- NCOEF, 24, filter taps
- COEF, all zero, packed taps, NCOEF*COEF_NBITS bits, c[0] in MSBs
- COEF_NBITS, 8, tap width (signed)
- COEF_FBITS, 7, tap fractional bits
- DATA_NBITS, 8, input sample width (signed)
- DATA_FBITS, 7, input fractional bits
- OUT_NBITS, 8, soft output width (signed)
- OUT_FBITS, 7, soft output fractional bits; must be ≤ DATA_FBITS+COEF_FBITS
- LOG_WIN, 3, phase-search window = 2^LOG_WIN symbols
- clk  in  1  system clock; one clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  clock-enable; low freezes all state
- rx_in  in  DATA_NBITS  signed input sample
- auto_en  in  1  1 = automatic phase, 0 = phase_in
- phase_in  in  clog2(UPSAMPLE)  manual decimation phase
- rx_out  out  1  hard decision, 1 = non-negative filter output
- soft_out  out  OUT_NBITS  saturated filter output at decision
- sym_valid  out  1  one-cycle strobe: rx_out/soft_out updated
- phase_out  out  clog2(UPSAMPLE)  phase currently in use
- locked  out  1  at least one search window completed since reset

## Operation
- Taps loaded from COEF on reset. Pipeline: registered products x*c[i], then transposed adder chain. FULL = DATA_NBITS+COEF_NBITS+clog2(NCOEF), FULL_FBITS = DATA_FBITS+COEF_FBITS; no internal overflow.
- Impulse of value x at rx_in on enabled edge t gives filter output y = x*c[NCOEF-1] at edge t+2, …, x*c[0] at edge t+1+NCOEF.
- clk_counter: 0..UPSAMPLE-1, wraps; increments each enabled cycle.
- Active phase P = phase_in when auto_en=0, else internal phase_sel. phase_out = P.
- Decision: on enabled edge with clk_counter==P: rx_out <= ~sign(y); soft_out <= sat(y >>> (FULL_FBITS-OUT_FBITS)) to OUT_NBITS; sym_valid <= 1. Otherwise sym_valid <= 0.
- Saturation: values > 2^(OUT_NBITS-1)-1 clamp to max, < -2^(OUT_NBITS-1) clamp to min. Shift is arithmetic (floor).
- Energy search (always running, independent of auto_en): acc[clk_counter] += |y| each enabled cycle. |y| is unsigned FULL bits; acc width is FULL+LOG_WIN; no overflow.
- win_cnt increments when clk_counter==UPSAMPLE-1.
- At the edge where clk_counter==UPSAMPLE-1 and win_cnt==2^LOG_WIN-1:
  - phase_sel <= argmax(acc), including the current cycle's contribution; ties resolve to the lowest index.
  - All acc cleared to 0; win_cnt wraps to 0; locked <= 1.
- Phase change, whether from a phase_sel update or from phase_in/auto_en switching, takes effect the next cycle. One symbol may be dropped or duplicated at a switch; no other glitch is allowed.
- enable=0: every register holds; sym_valid forced 0.

## Timing
- Reset values: rx_out=0, soft_out=0, sym_valid=0, phase_out=phase_in if auto_en=0 else 0, locked=0. phase_sel, clk_counter, win_cnt, acc, products and chain all reset to 0.
- Reset mid-window discards partial accumulation; the next window starts from 0.
- Latency: rx_in to y is 2 cycles (first tap); y to outputs is 1 cycle, at the decision edge.
- Exactly one sym_valid per UPSAMPLE enabled cycles in steady state.
- First window completes UPSAMPLE*2^LOG_WIN enabled cycles after reset release.

## Test plan
- Reset: assert rst mid-stream -> all outputs at reset values immediately (asynchronous); locked=0 until a full new window has completed.
- Impulse: NCOEF=4, COEF={8'h10,8'h20,8'h30,8'h40}, rx_in=64 for one cycle, auto_en=0 -> y = 4096, 3072, 2048, 1024 on edges t+2..t+5; a decision at t+2 phase gives soft_out=32, rx_out=1.
- Saturation: COEF all 8'h7F, rx_in held at 127 -> soft_out=127; rx_in held at -128 -> soft_out=-128, rx_out=0.
- Auto phase: COEF={0,0,0,8'h7F}, LOG_WIN=3, rx_in=±100 only when counter==2, else 0 -> after 32 cycles phase_out=0, locked=1; decisions thereafter match the transmitted signs.
- Manual override: same stimulus with auto_en=0, phase_in=1 -> soft_out=0 on every strobe; switching phase_in to 0 -> correct symbols from the next symbol onward.
- Enable gating: drop enable for 5 cycles mid-window -> no sym_valid pulses, all state frozen; the window completes 5 cycles later than nominal.
